// File: rtl/sram_device_responder.sv
// sram_device_responder: device end of an async 32-bit SRAM pin bus with byte-pair lanes and fixed read latency.
module sram_device_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int READ_LAT  = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [16:0]      SRAM_ADDR,
  inout  wire  [31:0]      SRAM_DQ,
  input  logic             SRAM_CE_N,
  input  logic             SRAM_OE_N,
  input  logic             SRAM_WE_N,
  input  logic             SRAM_UB_N,
  input  logic             SRAM_LB_N,
  output logic             dq_drive,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic             err_conflict
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [1:0] IDLE = 2'd0, RD_WAIT = 2'd1, RD_DRIVE = 2'd2, WR_HOLD = 2'd3;
  logic [31:0] mem [MEM_WORDS];
  logic [1:0] state_q, state_d, wlanes_q, wlanes_d;
  logic [2:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d, waddr_q, waddr_d, idx;
  logic [31:0] wdata_q, wdata_d, dout_q, dout_d, mem_rd, fwd;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
  logic err_q, rd, wr, conflict, commit, rd_load, start_rd, hit;
  logic unused_addr_hi;
  assign idx = SRAM_ADDR[AW-1:0];
  assign unused_addr_hi = ^SRAM_ADDR[16:AW];
  assign rd = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign wr = !SRAM_CE_N && !SRAM_WE_N;
  assign conflict = !SRAM_CE_N && !SRAM_OE_N && !SRAM_WE_N;
  assign commit = state_q == WR_HOLD && !wr && |wlanes_q;
  assign mem_rd = mem[idx];
  // A read loaded on the very edge that commits a write must see the new data.
  assign hit = state_q == WR_HOLD && waddr_q == idx;
  assign fwd = {hit && wlanes_q[1] ? wdata_q[31:16] : mem_rd[31:16],
                hit && wlanes_q[0] ? wdata_q[15:0]  : mem_rd[15:0]};
  assign dq_drive = state_q == RD_DRIVE && !conflict;
  assign SRAM_DQ = dq_drive ? dout_q : 'z;
  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
  assign err_conflict = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wlanes_d = wlanes_q;
    dout_d = dout_q;
    rd_load = 1'b0;
    start_rd = 1'b0;
    if (wr) begin
      state_d = WR_HOLD;
      waddr_d = idx;
      wdata_d = SRAM_DQ;
      wlanes_d = {!SRAM_UB_N, !SRAM_LB_N};
    end else if (state_q == WR_HOLD) begin
      state_d = IDLE;
      start_rd = rd;
    end else if (!rd) begin
      state_d = IDLE;
    end else if (state_q == IDLE || addr_q != idx) begin
      start_rd = 1'b1;
    end else if (state_q == RD_WAIT) begin
      if (cnt_q == 3'(READ_LAT - 1)) begin
        state_d = RD_DRIVE;
        rd_load = 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
    if (start_rd) begin
      addr_d = idx;
      cnt_d = 3'd1;
      state_d = READ_LAT == 1 ? RD_DRIVE : RD_WAIT;
      rd_load = READ_LAT == 1;
    end
    if (rd_load) dout_d = fwd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wlanes_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wlanes_q <= wlanes_d;
      wr_cnt_q <= wr_cnt_q + CNT_W'(commit);
      rd_cnt_q <= rd_cnt_q + CNT_W'(rd_load);
      err_q <= err_q || conflict;
    end
  end
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
    dout_q <= dout_d;
  end
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      if (wlanes_q[1]) mem[waddr_q][31:16] <= wdata_q[31:16];
      if (wlanes_q[0]) mem[waddr_q][15:0] <= wdata_q[15:0];
    end
  end
endmodule
